cond_flag_unit: RTL and testbench

//  Status-flag register and condition-check stage sitting directly downstream of the 32-bit ALU.
//  - Latches N,Z,C,V from the ALU on flag-setting ops.
//  - Feeds the stored carry back to the ALU C_In.
//  - Evaluates the 4-bit condition field of the instruction leaving ID and registers a pass/fail into EX.
//  - Stalls ID when a flag write and a dependent condition collide (bypass build omitted).

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_eval.sv | 46 ++++
 rtl/cond_flag_unit.sv | 142 ++++++++++++++
 tb/tb_cond_flag_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the condition-check stage and any branch logic that
// reuses the condition evaluator.
//   - condition-code encodings COND_EQ .. COND_NV (ARM style)
//   - bit positions of N, Z, C, V inside the packed {N,Z,C,V} flag word
//   - state encoding of the flag/condition hazard FSM
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_EVAL = 1'b0,
    ST_WAIT = 1'b1
  } cond_state_e;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition evaluator: (condition code, {N,Z,C,V}) -> pass.
// Shared between the EX condition stage and branch resolution.
// Ports:
//   cond_i   condition field
//   flags_i  {N,Z,C,V}
//   pass_o   1 when the condition holds
module cond_eval
  import cond_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] cond_i,
  input  logic [3:0]        flags_i,
  output logic              pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLG_N];
  assign z = flags_i[FLG_Z];
  assign c = flags_i[FLG_C];
  assign v = flags_i[FLG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;   // NV
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Status-flag register and condition-check stage downstream of the 32-bit ALU.
// Latches N,Z,C,V on flag-setting ops, feeds the stored carry back to the ALU,
// evaluates the condition of the instruction leaving ID and registers the
// pass/fail into EX.
//
// Build option: COND_BYPASS_EN
//   defined   - condition is evaluated against this cycle's next-flag value,
//               no hazard stall (zero bubble); FSM parked in ST_EVAL.
//   undefined - condition uses the registered flags; a flag write colliding
//               with a dependent condition stalls ID for one cycle.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   flag_wr_i, arith_i,        ALU flag update controls
//   sub_op_i
//   n/z/c/v_alu_i              ALU flag outputs
//   flag_ld_i, flag_data_i     direct status-register load (beats flag_wr_i)
//   cond_i, cond_valid_i       condition field / valid of instruction in ID
//   stall_i                    pipeline hold
//   flags_o                    registered {N,Z,C,V}
//   c_fwd_o                    stored carry to ALU C_In
//   cond_pass_o                EX instruction passed its condition
//   cond_stall_o               hold ID/IF this cycle
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_EVAL | normal: evaluate condition, stall on flag/condition collision
// ST_WAIT | bubble issued; flags now settled, re-evaluate held instruction
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int         COND_W      = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flag_wr_i,
  input  logic              arith_i,
  input  logic              sub_op_i,
  input  logic              n_alu_i,
  input  logic              z_alu_i,
  input  logic              c_alu_i,
  input  logic              v_alu_i,
  input  logic              flag_ld_i,
  input  logic [3:0]        flag_data_i,
  input  logic [COND_W-1:0] cond_i,
  input  logic              cond_valid_i,
  input  logic              stall_i,
  output logic [3:0]        flags_o,
  output logic              c_fwd_o,
  output logic              cond_pass_o,
  output logic              cond_stall_o
);

  logic [3:0]  flags_q, flags_d;
  logic        cond_pass_q, cond_pass_d;
  cond_state_e state_q, state_d;
  logic [3:0]  eval_flags;
  logic        eval_pass;
  logic        collide;

  // Next-flag value; updates regardless of stall_i.
  always_comb begin
    flags_d = flags_q;
    if (flag_ld_i) begin
      flags_d = flag_data_i;
    end else if (flag_wr_i) begin
      flags_d[FLG_N] = n_alu_i;
      flags_d[FLG_Z] = z_alu_i;
      if (arith_i) begin
        // ALU reports borrow on subtract; store ARM-style carry.
        flags_d[FLG_C] = c_alu_i ^ sub_op_i;
        flags_d[FLG_V] = v_alu_i;
      end
    end
  end

  // AL and NV do not read flags, so they never form a hazard.
  assign collide = ~stall_i & cond_valid_i & (flag_wr_i | flag_ld_i) &
                   (cond_i != COND_AL) & (cond_i != COND_NV);

`ifdef COND_BYPASS_EN
  assign eval_flags = flags_d;

  always_comb begin
    state_d = ST_EVAL;
  end

  always_comb begin
    cond_stall_o = 1'b0;
  end
`else
  assign eval_flags = flags_q;

  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      state_d = collide ? ST_WAIT : ST_EVAL;
    end
  end

  // A fresh flag write while already in WAIT re-arms the stall.
  always_comb begin
    cond_stall_o = 1'b0;
    case (state_q)
      ST_EVAL: cond_stall_o = collide & ~rst_i;
      ST_WAIT: cond_stall_o = collide & ~rst_i;
      default: cond_stall_o = 1'b0;
    endcase
  end
`endif

  cond_eval #(.COND_W(COND_W)) u_cond_eval (
    .cond_i  (cond_i),
    .flags_i (eval_flags),
    .pass_o  (eval_pass)
  );

  always_comb begin
    cond_pass_d = cond_pass_q;
    if (!stall_i) begin
      cond_pass_d = cond_stall_o ? 1'b0 : (cond_valid_i & eval_pass);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q     <= RESET_FLAGS;
      cond_pass_q <= 1'b0;
      state_q     <= ST_EVAL;
    end else begin
      flags_q     <= flags_d;
      cond_pass_q <= cond_pass_d;
      state_q     <= state_d;
    end
  end

  assign flags_o     = flags_q;
  assign c_fwd_o     = flags_q[FLG_C];
  assign cond_pass_o = cond_pass_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst, flag_wr, arith, sub_op, n_alu, z_alu, c_alu, v_alu;
  logic       flag_ld, cond_valid, stall;
  logic [3:0] flag_data, cond;
  logic [3:0] flags;
  logic       c_fwd, cond_pass, cond_stall;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [3:0] m_flags;
  logic       m_pass;
  bit         m_valid = 0;

  always #5 clk = ~clk;

  cond_flag_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flag_wr_i    (flag_wr),
    .arith_i      (arith),
    .sub_op_i     (sub_op),
    .n_alu_i      (n_alu),
    .z_alu_i      (z_alu),
    .c_alu_i      (c_alu),
    .v_alu_i      (v_alu),
    .flag_ld_i    (flag_ld),
    .flag_data_i  (flag_data),
    .cond_i       (cond),
    .cond_valid_i (cond_valid),
    .stall_i      (stall),
    .flags_o      (flags),
    .c_fwd_o      (c_fwd),
    .cond_pass_o  (cond_pass),
    .cond_stall_o (cond_stall)
  );

  // Condition codes come in true/inverted pairs; bit 0 selects the inverse.
  function automatic logic ref_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic logic [3:0] ref_next_flags();
    logic [3:0] f;
    f = m_flags;
    if (flag_ld) f = flag_data;
    else if (flag_wr) begin
      f[3] = n_alu;
      f[2] = z_alu;
      if (arith) begin
        f[1] = sub_op ? !c_alu : c_alu;
        f[0] = v_alu;
      end
    end
    return f;
  endfunction

  function automatic logic ref_stall();
`ifdef COND_BYPASS_EN
    return 1'b0;
`else
    return !rst && !stall && cond_valid && (flag_wr || flag_ld) && cond < 4'hE;
`endif
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; flag_wr = 0; arith = 0; sub_op = 0;
    n_alu = 0; z_alu = 0; c_alu = 0; v_alu = 0;
    flag_ld = 0; flag_data = 4'h0; cond = 4'hE; cond_valid = 0; stall = 0;
  endtask

  // Called after inputs were applied at the falling edge.
  task automatic cmp_model();
    #1;
    if (m_valid) begin
      chk("m_flags", flags, m_flags);
      chk("m_c_fwd", {3'b0, c_fwd}, {3'b0, m_flags[1]});
      chk("m_pass", {3'b0, cond_pass}, {3'b0, m_pass});
      chk("m_stall", {3'b0, cond_stall}, {3'b0, ref_stall()});
    end
  endtask

  task automatic tick();
    logic [3:0] nf;
    logic       np;
    @(posedge clk);
    nf = ref_next_flags();
    if (rst) begin
      nf = 4'h0;
      np = 1'b0;
      m_valid = 1;
    end else if (stall) begin
      np = m_pass;
    end else if (ref_stall()) begin
      np = 1'b0;
    end else begin
`ifdef COND_BYPASS_EN
      np = cond_valid && ref_eval(cond, nf);
`else
      np = cond_valid && ref_eval(cond, m_flags);
`endif
    end
    m_flags = nf;
    m_pass  = np;
    #1;
  endtask

  logic exp_col_stall, exp_col_pass;

  initial begin
`ifdef COND_BYPASS_EN
    exp_col_stall = 1'b0; exp_col_pass = 1'b1;
`else
    exp_col_stall = 1'b1; exp_col_pass = 1'b0;
`endif
    idle();

    // reset
    @(negedge clk); idle(); rst = 1; cmp_model(); tick();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_pass", {3'b0, cond_pass}, 4'h0);
    chk("rst_cfwd", {3'b0, c_fwd}, 4'h0);
    @(negedge clk); idle(); cmp_model();
    chk("rst_stall", {3'b0, cond_stall}, 4'h0);
    tick();

    // subtract A-B with A==B
    @(negedge clk); idle(); flag_wr = 1; arith = 1; sub_op = 1; z_alu = 1; cmp_model(); tick();
    chk("sub_flags", flags, 4'b0110);
    @(negedge clk); idle(); cond = 4'h0; cond_valid = 1; cmp_model(); tick();
    chk("eq_pass", {3'b0, cond_pass}, 4'h1);
    @(negedge clk); idle(); cond = 4'h8; cond_valid = 1; cmp_model(); tick();
    chk("hi_fail", {3'b0, cond_pass}, 4'h0);

    // logical op keeps C,V
    @(negedge clk); idle(); flag_ld = 1; flag_data = 4'b0011; cmp_model(); tick();
    @(negedge clk); idle(); flag_wr = 1; n_alu = 1; c_alu = 0; v_alu = 0; cmp_model(); tick();
    chk("logic_flags", flags, 4'b1011);
    @(negedge clk); idle(); cond = 4'hA; cond_valid = 1; cmp_model(); tick();
    chk("ge_pass", {3'b0, cond_pass}, 4'h1);
    @(negedge clk); idle(); cond = 4'hB; cond_valid = 1; cmp_model(); tick();
    chk("lt_fail", {3'b0, cond_pass}, 4'h0);

    // flag write colliding with a dependent condition (Z 0 -> 1, EQ)
    @(negedge clk); idle(); flag_wr = 1; arith = 1; z_alu = 1; c_alu = 1; v_alu = 1;
    cond = 4'h0; cond_valid = 1; cmp_model();
    chk("col_stall", {3'b0, cond_stall}, {3'b0, exp_col_stall});
    tick();
    chk("col_flags", flags, 4'b0111);
    chk("col_pass", {3'b0, cond_pass}, {3'b0, exp_col_pass});
    @(negedge clk); idle(); cond = 4'h0; cond_valid = 1; cmp_model();
    chk("wait_stall", {3'b0, cond_stall}, 4'h0);
    tick();
    chk("wait_pass", {3'b0, cond_pass}, 4'h1);

    // reset in the middle of a collision
    @(negedge clk); idle(); flag_wr = 1; cond = 4'h1; cond_valid = 1; cmp_model(); tick();
    @(negedge clk); idle(); rst = 1; flag_wr = 1; cond = 4'h1; cond_valid = 1; cmp_model();
    chk("rst_mid_stall", {3'b0, cond_stall}, 4'h0);
    tick();
    chk("rst_mid_pass", {3'b0, cond_pass}, 4'h0);
    chk("rst_mid_flags", flags, 4'h0);

    // load beats write, stall holds pass, NV never passes
    @(negedge clk); idle(); flag_ld = 1; flag_data = 4'hF; flag_wr = 1; arith = 1; cmp_model(); tick();
    chk("ld_flags", flags, 4'hF);
    chk("ld_cfwd", {3'b0, c_fwd}, 4'h1);
    @(negedge clk); idle(); cond = 4'h0; cond_valid = 1; cmp_model(); tick();
    chk("eq_pass2", {3'b0, cond_pass}, 4'h1);
    @(negedge clk); idle(); stall = 1; cond = 4'hF; cond_valid = 1; flag_wr = 1; cmp_model();
    chk("stall_nostall", {3'b0, cond_stall}, 4'h0);
    tick();
    chk("stall_hold", {3'b0, cond_pass}, 4'h1);
    @(negedge clk); idle(); cond = 4'hF; cond_valid = 1; cmp_model(); tick();
    chk("nv_fail", {3'b0, cond_pass}, 4'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 63) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      flag_ld    = ($urandom_range(0, 7) == 0);
      flag_wr    = $urandom_range(0, 1);
      arith      = $urandom_range(0, 1);
      sub_op     = $urandom_range(0, 1);
      n_alu      = $urandom_range(0, 1);
      z_alu      = $urandom_range(0, 1);
      c_alu      = $urandom_range(0, 1);
      v_alu      = $urandom_range(0, 1);
      flag_data  = 4'($urandom_range(0, 15));
      cond       = 4'($urandom_range(0, 15));
      cond_valid = ($urandom_range(0, 3) != 0);
      cmp_model();
      tick();
    end
    @(negedge clk); idle(); cmp_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
